// File: rtl/mulcpu_pkg.sv
// mulcpu_pkg -- shared definitions for the MEM stage of the multi-cycle CPU.
//   * mem_state_e : data-memory handshake FSM states (IDLE, BUSY)
//   * exmem_t     : contents of the EXE/MEM pipeline register
//   * TIMEOUT_CYCLES_DEF : default dm_ack watchdog limit
package mulcpu_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        branch;
    logic        zero;
    logic [31:0] aluR;
    logic [31:0] inB;
    logic [31:0] pc;
    logic [4:0]  destR;
    logic [3:0]  ins_type;
    logic [3:0]  ins_number;
  } exmem_t;

endpackage

// File: rtl/Reg_EXE_MEM.sv
// Reg_EXE_MEM -- EXE/MEM pipeline register with hold.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset, clears the whole register
//   hold_i : 1 = keep current contents (MEM stage stalled)
//   d_i    : values coming from the EX stage
//   q_o    : registered values seen by the MEM stage
module Reg_EXE_MEM
  import mulcpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold_i,
  input  exmem_t d_i,
  output exmem_t q_o
);

  exmem_t data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (!hold_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage: EXE/MEM register, data-memory handshake
// FSM (IDLE/BUSY) and forwarding of results to WB and branch info to IF.
// Ports:
//   clk, rst            : clock (rising edge) and async active-low reset
//   ex_*, EXE_ins_*     : EX-stage controls, operands and trace tags
//   dm_req/dm_we/dm_addr/dm_wdata : request side of the data memory
//   dm_rdata/dm_ack     : read data and completion from the data memory
//   mem_stall           : freezes all upstream stages while waiting on memory
//   mem_*, MEM_ins_*    : results and controls toward WB / IF, trace tags
//   mem_err             : sticky memory-timeout flag
// Optional feature: define MEM_ACK_TIMEOUT_EN to enable a dm_ack watchdog of
// TIMEOUT_CYCLES BUSY cycles; otherwise mem_err is 0 and BUSY waits forever.
module mem_stage
  import mulcpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic        ex_branch,
  input  logic        ex_zero,
  input  logic [31:0] ex_aluR,
  input  logic [31:0] ex_inB,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_destR,
  input  logic [3:0]  EXE_ins_type,
  input  logic [3:0]  EXE_ins_number,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_stall,
  output logic        mem_wreg,
  output logic        mem_m2reg,
  output logic [31:0] mem_aluR,
  output logic [31:0] mem_mdata,
  output logic [4:0]  mem_destR,
  output logic        mem_pcsrc,
  output logic [31:0] mem_branch_pc,
  output logic [3:0]  MEM_ins_type,
  output logic [3:0]  MEM_ins_number,
  output logic        mem_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  exmem_t     ex_d;
  exmem_t     r_q;
  mem_state_e state_q, state_d;
  logic       busy;
  logic       tmo;

  always_comb begin
    ex_d            = '0;
    ex_d.wreg       = ex_wreg;
    ex_d.m2reg      = ex_m2reg;
    ex_d.wmem       = ex_wmem;
    ex_d.branch     = ex_branch;
    ex_d.zero       = ex_zero;
    ex_d.aluR       = ex_aluR;
    ex_d.inB        = ex_inB;
    ex_d.pc         = ex_pc;
    ex_d.destR      = ex_destR;
    ex_d.ins_type   = EXE_ins_type;
    ex_d.ins_number = EXE_ins_number;
  end

  // EX -> MEM boundary
  Reg_EXE_MEM u_reg (
    .clk    (clk),
    .rst    (rst),
    .hold_i (mem_stall),
    .d_i    (ex_d),
    .q_o    (r_q)
  );

  assign busy = (state_q == BUSY);

`ifdef MEM_ACK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  // The TIMEOUT_CYCLES-th BUSY cycle without ack completes the access.
  assign tmo = busy & ~dm_ack & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (busy && !dm_ack && !tmo) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | tmo;
    end
  end

  assign mem_err = err_q;
`else
  assign tmo     = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Ack is only meaningful while BUSY; IDLE never stalls.
  assign mem_stall = busy & ~(dm_ack | tmo);

  always_comb begin
    state_d = state_q;
    if (!mem_stall) begin
      // Capture edge: the incoming instruction decides the next state,
      // so back-to-back memory ops go straight from BUSY to BUSY.
      state_d = (ex_m2reg | ex_wmem) ? BUSY : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign dm_req   = busy;
  assign dm_we    = busy & r_q.wmem;
  assign dm_addr  = r_q.aluR;
  assign dm_wdata = r_q.inB;

  // Load data is only valid in the ack cycle; zero elsewhere so reset and
  // stray acks never leak read data.
  assign mem_mdata      = (busy & dm_ack) ? dm_rdata : 32'd0;
  assign mem_wreg       = r_q.wreg & ~mem_stall & ~tmo;
  assign mem_m2reg      = r_q.m2reg;
  assign mem_aluR       = r_q.aluR;
  assign mem_destR      = r_q.destR;
  assign mem_pcsrc      = r_q.branch & r_q.zero;
  assign mem_branch_pc  = r_q.pc;
  assign MEM_ins_type   = r_q.ins_type;
  assign MEM_ins_number = r_q.ins_number;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the dm_ack watchdog limit in cycles (used only with MEM_ACK_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports ex_wreg, ex_m2reg, ex_wmem, ex_branch and ex_zero, each input, 1 bit: EX-stage control bits and ALU zero flag.
REQ-005 SHALL have ports ex_aluR, ex_inB and ex_pc, each input, 32 bits: ALU result/address, store data, and branch target.
REQ-006 SHALL have port ex_destR, input, 5 bits: destination register number.
REQ-007 SHALL have ports EXE_ins_type and EXE_ins_number, each input, 4 bits: instruction trace tags.
REQ-008 SHALL have ports dm_req and dm_we, each output, 1 bit: data-memory request and write enable.
REQ-009 SHALL have ports dm_addr and dm_wdata, each output, 32 bits: data-memory address and write data.
REQ-010 SHALL have ports dm_rdata, input, 32 bits, and dm_ack, input, 1 bit: data-memory read data and completion.
REQ-011 SHALL have port mem_stall, output, 1 bit: freeze of all upstream stages.
REQ-012 SHALL have ports mem_wreg and mem_m2reg, each output, 1 bit: controls to WB.
REQ-013 SHALL have ports mem_aluR and mem_mdata, each output, 32 bits: ALU result and load data to WB.
REQ-014 SHALL have port mem_destR, output, 5 bits: destination register number to WB.
REQ-015 SHALL have ports mem_pcsrc, output, 1 bit, and mem_branch_pc, output, 32 bits: taken-branch select and target to IF.
REQ-016 SHALL have ports MEM_ins_type and MEM_ins_number, each output, 4 bits: trace tags.
REQ-017 SHALL have port mem_err, output, 1 bit: sticky memory-timeout flag.

Function
REQ-018 SHALL capture all ex_* inputs and trace tags into the EXE/MEM register on each clk edge with mem_stall=0, and SHALL hold them while mem_stall=1.
REQ-019 SHALL implement FSM states IDLE and BUSY.
REQ-020 At a capture edge, FSM SHALL go to BUSY if the captured ex_m2reg|ex_wmem=1, else to IDLE; BUSY with dm_ack=0 SHALL stay BUSY.
REQ-021 dm_req SHALL equal (state==BUSY); dm_we SHALL equal BUSY & wmem_q; dm_addr=aluR_q and dm_wdata=inB_q SHALL stay stable while dm_req=1.
REQ-022 mem_stall SHALL equal BUSY & ~dm_ack, so zero-wait ack gives 1-cycle access and each extra wait cycle adds exactly one stall cycle.
REQ-023 mem_mdata SHALL equal dm_rdata and is valid only in the ack cycle.
REQ-024 mem_wreg SHALL equal wreg_q & ~mem_stall.
REQ-025 mem_m2reg, mem_aluR, mem_destR and the trace tags SHALL mirror the register contents.
REQ-026 mem_pcsrc SHALL equal branch_q & zero_q, and mem_branch_pc SHALL equal pc_q.
REQ-027 dm_ack while IDLE SHALL be ignored.
REQ-028 When m2reg_q and wmem_q are both 1, the access SHALL be a store (dm_we=1).
REQ-029 Back-to-back accesses SHALL return to BUSY at the ack edge, with no IDLE cycle.

Reset
REQ-030 rst=0 SHALL asynchronously clear every register and force IDLE, so that all outputs read 0 and dm_req drops immediately, including mid-transaction.
REQ-031 A dm_ack arriving after reset abort SHALL be ignored.

Configuration
REQ-032 With MEM_ACK_TIMEOUT_EN defined, a counter SHALL count BUSY cycles without ack.
REQ-033 With MEM_ACK_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES the access SHALL complete as if acked, with mem_wreg forced 0 for that cycle, and mem_err SHALL set and stay set until reset.
REQ-034 Without MEM_ACK_TIMEOUT_EN, there SHALL be no counter, mem_err SHALL be tied 0, and BUSY SHALL wait indefinitely.

Structure
REQ-035 Package mulcpu_pkg SHALL hold the FSM state encodings and the TIMEOUT_CYCLES default.
REQ-036 The EXE/MEM pipeline register SHALL be sub-module Reg_EXE_MEM with a hold (stall) input.

Verification
REQ-037 Load: ex_m2reg=1, ex_wreg=1, aluR=0x100, ack after 2 wait cycles with rdata=0xDEADBEEF -> dm_req 3 cycles, mem_stall 2 cycles, mem_wreg=1 and mem_mdata=0xDEADBEEF in the ack cycle.
REQ-038 Store: ex_wmem=1, aluR=0x40, inB=0x1234, zero-wait ack -> dm_we=1, dm_addr=0x40, dm_wdata=0x1234 for 1 cycle, no stall.
REQ-039 Branch: ex_branch=1, ex_zero=1, ex_pc=0x80 -> mem_pcsrc=1, mem_branch_pc=0x80 next cycle; with ex_zero=0 -> mem_pcsrc=0.
REQ-040 Reset mid-access: rst=0 during BUSY -> dm_req=0 immediately, late ack ignored, outputs 0.
REQ-041 Back-to-back load-store, each acked after 1 wait cycle -> 4 dm_req cycles, no IDLE gap.
REQ-042 With MEM_ACK_TIMEOUT_EN and no ack -> completion after 16 cycles, mem_err=1 and held, mem_wreg=0.
